// File: rtl/aqed_dup_write_injector.sv
// aqed_dup_write_injector: passes the write stream to the memory core, captures one tagged
// original write and injects exactly one duplicate of it on request, reporting both positions.
module aqed_dup_write_injector #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              mark_orig,
    input  logic              exec_dup,
    input  logic              full,
    output logic              wen_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  orig_pos,
    output logic [CNT_W-1:0]  dup_pos,
    output logic              orig_done,
    output logic              dup_done
);
    typedef enum logic [1:0] {CAPTURE, ARMED, DONE} state_t;
    state_t state;
    logic [DATA_W-1:0] orig_val;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic dup_slot;
    logic accept;
    logic issue_dup;
    // The duplicate owns the write port whenever it is requested while armed, even if full stalls it.
    assign dup_slot  = state == ARMED && exec_dup;
    assign in_ready  = !full && !dup_slot;
    assign accept    = in_valid && in_ready;
    assign issue_dup = dup_slot && !full;
    assign cnt_next  = &wr_cnt ? wr_cnt : wr_cnt + 1'b1;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= CAPTURE;
            orig_val  <= '0;
            wr_cnt    <= '0;
            wen_out   <= 1'b0;
            data_out  <= '0;
            orig_pos  <= '0;
            dup_pos   <= '0;
            orig_done <= 1'b0;
            dup_done  <= 1'b0;
        end else begin
            wen_out <= accept || issue_dup;
            if (issue_dup) begin
                data_out <= orig_val;
                dup_pos  <= wr_cnt;
                dup_done <= 1'b1;
                state    <= DONE;
            end else if (accept) begin
                data_out <= in_data;
                if (state == CAPTURE && mark_orig) begin
                    orig_val  <= in_data;
                    orig_pos  <= wr_cnt;
                    orig_done <= 1'b1;
                    state     <= ARMED;
                end
            end
            if (accept || issue_dup)
                wr_cnt <= cnt_next;
        end
    end
endmodule

// File: tb/tb_aqed_dup_write_injector.sv
// tb_aqed_dup_write_injector: table vectors, directed corner sequences and random traffic
// checked against a stream-level model of the injector.
module tb_aqed_dup_write_injector;
    localparam int DW   = 16;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mark_orig;
    logic          exec_dup;
    logic          full;
    logic          wen_out;
    logic [DW-1:0] data_out;
    logic [CW-1:0] orig_pos;
    logic [CW-1:0] dup_pos;
    logic          orig_done;
    logic          dup_done;

    aqed_dup_write_injector #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mark_orig(mark_orig), .exec_dup(exec_dup), .full(full), .wen_out(wen_out),
        .data_out(data_out), .orig_pos(orig_pos), .dup_pos(dup_pos), .orig_done(orig_done),
        .dup_done(dup_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = waiting for tag, 1 = original held, 2 = duplicate spent.
    int            m_phase;
    int            m_cnt;
    int            m_orig_pos;
    int            m_dup_pos;
    logic [DW-1:0] m_orig_val;
    logic [DW-1:0] m_data;
    bit            m_wen;
    bit            m_od;
    bit            m_dd;

    typedef struct {
        bit            v;
        logic [DW-1:0] d;
        bit            m;
        bit            e;
        bit            f;
        bit            rdy;
        bit            wen;
        logic [DW-1:0] data;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".wen_out"}, 32'(wen_out), 32'(m_wen));
        chk({tag, ".data_out"}, 32'(data_out), 32'(m_data));
        chk({tag, ".orig_pos"}, 32'(orig_pos), 32'(m_orig_pos));
        chk({tag, ".dup_pos"}, 32'(dup_pos), 32'(m_dup_pos));
        chk({tag, ".orig_done"}, 32'(orig_done), 32'(m_od));
        chk({tag, ".dup_done"}, 32'(dup_done), 32'(m_dd));
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_orig_pos = 0; m_dup_pos = 0;
        m_orig_val = '0; m_data = '0; m_wen = 0; m_od = 0; m_dd = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b1; in_data = DW'($urandom); mark_orig = 1'b1;
        exec_dup = 1'b1; full = 1'b1;
        #1;
        model_reset();
        check_outs("reset_async");
        chk("reset.in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset_held");
        reset = 1'b1; in_valid = 1'b0; mark_orig = 1'b0; exec_dup = 1'b0; full = 1'b0;
    endtask

    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit m, input bit e,
                         input bit f, output bit rdy_act);
        bit rdy, acc, dup;
        in_valid = v; in_data = d; mark_orig = m; exec_dup = e; full = f;
        #1;
        rdy = !f && !(m_phase == 1 && e);
        rdy_act = in_ready;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        dup = m_phase == 1 && e && !f;
        acc = v && rdy;
        if (dup) begin
            m_data = m_orig_val; m_dup_pos = m_cnt; m_dd = 1; m_phase = 2;
        end else if (acc) begin
            m_data = d;
            if (m_phase == 0 && m) begin
                m_orig_val = d; m_orig_pos = m_cnt; m_od = 1; m_phase = 1;
            end
        end
        m_wen = dup || acc;
        if (dup || acc) m_cnt = m_cnt < MAXC ? m_cnt + 1 : MAXC;
        @(posedge clk);
        #1;
        check_outs("cycle");
    endtask

    initial begin
        bit r;
        tbl[0] = '{1, 16'h11, 0, 0, 0, 1, 1, 16'h11};
        tbl[1] = '{1, 16'h22, 1, 0, 0, 1, 1, 16'h22};
        tbl[2] = '{1, 16'h33, 0, 0, 0, 1, 1, 16'h33};
        tbl[3] = '{1, 16'h44, 0, 1, 0, 0, 1, 16'h22};
        tbl[4] = '{1, 16'h44, 0, 1, 0, 1, 1, 16'h44};
        tbl[5] = '{0, 16'h00, 0, 0, 0, 1, 0, 16'h44};
        #1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].m, tbl[i].e, tbl[i].f, r);
            chk($sformatf("tbl%0d.rdy", i), 32'(r), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d.wen", i), 32'(wen_out), 32'(tbl[i].wen));
            chk($sformatf("tbl%0d.data", i), 32'(data_out), 32'(tbl[i].data));
        end
        chk("t2.orig_pos", 32'(orig_pos), 32'd1);
        chk("t3.dup_pos", 32'(dup_pos), 32'd3);

        do_reset();
        cycle(1, 16'h77, 1, 0, 0, r);
        repeat (3) begin
            cycle(1, 16'h88, 0, 1, 1, r);
            chk("t4.full_rdy", 32'(r), 32'd0);
            chk("t4.full_wen", 32'(wen_out), 32'd0);
        end
        cycle(1, 16'h88, 0, 1, 0, r);
        chk("t4.dup_data", 32'(data_out), 32'h77);
        chk("t4.dup_pos", 32'(dup_pos), 32'd1);
        cycle(1, 16'h88, 0, 1, 0, r);
        chk("t4.after_data", 32'(data_out), 32'h88);
        chk("t4.after_rdy", 32'(r), 32'd1);

        do_reset();
        cycle(1, 16'h55, 0, 1, 0, r);
        cycle(0, 16'h00, 1, 1, 0, r);
        cycle(1, 16'h66, 1, 0, 1, r);
        cycle(0, 16'h00, 0, 1, 0, r);
        chk("t5.orig_done", 32'(orig_done), 32'd0);
        chk("t5.dup_done", 32'(dup_done), 32'd0);

        do_reset();
        cycle(1, 16'h12, 0, 0, 0, r);
        cycle(1, 16'h34, 1, 0, 0, r);
        do_reset();
        chk("t6.orig_done", 32'(orig_done), 32'd0);
        cycle(1, 16'h56, 1, 0, 0, r);
        chk("t6.orig_pos", 32'(orig_pos), 32'd0);
        chk("t6.orig_done1", 32'(orig_done), 32'd1);

        do_reset();
        repeat (MAXC + 3) cycle(1, DW'($urandom), 0, 0, 0, r);
        cycle(1, 16'hAB, 1, 0, 0, r);
        chk("sat.orig_pos", 32'(orig_pos), 32'(MAXC));
        cycle(1, 16'hCD, 0, 1, 0, r);
        chk("sat.dup_pos", 32'(dup_pos), 32'(MAXC));
        chk("sat.dup_data", 32'(data_out), 32'hAB);

        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int n = 0; n < 250; n++) begin
                if ($urandom_range(99) == 0) do_reset();
                cycle($urandom_range(3) != 0, DW'($urandom), $urandom_range(7) == 0,
                      $urandom_range(3) == 0, $urandom_range(3) == 0, r);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
